// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// Holds the FSM encoding, the port identifier type and the address-range check.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic port_id_t;

    // The byte address is zero-extended to 64 bits by the caller.
    function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[63:2]} < depth);
    endfunction

endpackage

// File: rtl/dmem_rr_picker.sv
// Two-way round-robin pick: a sole requester wins; on a tie the port that
// did not win most recently (the one other than last_i) wins.
module dmem_rr_picker
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  port_id_t   last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one async-read / sync-write data memory between the CPU (port 0)
// and the DMA/debug loader (port 1) with round-robin, locked bursts and range checks.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int n         = 32,
    parameter int DEPTH     = 64,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_we,
    input  logic         req0_lock,
    input  logic [n-1:0] req0_addr,
    input  logic [n-1:0] req0_wdata,
    output logic         req0_rvalid,
    output logic [n-1:0] req0_rdata,
    output logic         req0_err,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_we,
    input  logic         req1_lock,
    input  logic [n-1:0] req1_addr,
    input  logic [n-1:0] req1_wdata,
    output logic         req1_rvalid,
    output logic [n-1:0] req1_rdata,
    output logic         req1_err,

    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata,

    output arb_state_t   dbg_state_o
);

    // Handshake: a request transfers on a cycle where valid & ready are both high.
    // ready is combinational from the grant; a requester holds every request input
    // stable while valid & !ready. Responses (rvalid/err) follow one cycle later.

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    port_id_t         last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic [1:0]       pick;
    logic [1:0]       grant;

    logic             sel_we;
    logic [n-1:0]     sel_addr;
    logic [n-1:0]     sel_wdata;
    logic             sel_legal;

    logic [1:0]       rvalid_q;
    logic [1:0]       err_q;
    logic [n-1:0]     rdata0_q;
    logic [n-1:0]     rdata1_q;

    dmem_rr_picker u_picker (
        .valid_i (({req1_valid, req0_valid})),
        .last_i  (last_q),
        .grant_o (pick)
    );

    assign cnt_inc = (cnt_q == CNT_W'(MAX_BURST)) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant   = 2'b00;
        case (state_q)
            IDLE: begin
                grant = pick;
                if (pick != 2'b00) begin
                    last_d = pick[1];
                    if (MAX_BURST > 1 && (pick[1] ? req1_lock : req0_lock)) begin
                        state_d = pick[1] ? OWN1 : OWN0;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            OWN0: begin
                grant = {1'b0, req0_valid};
                if (!req0_valid || !req0_lock || cnt_inc == CNT_W'(MAX_BURST)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            OWN1: begin
                grant = {req1_valid, 1'b0};
                if (!req1_valid || !req1_lock || cnt_inc == CNT_W'(MAX_BURST)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    last_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Nothing is accepted while reset is asserted, so an in-flight request is dropped.
        if (!rst_n) begin
            grant = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (grant[0]) begin
            sel_we    = req0_we;
            sel_addr  = req0_addr;
            sel_wdata = req0_wdata;
        end else if (grant[1]) begin
            sel_we    = req1_we;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end
    end

    assign sel_legal  = addr_legal(64'(sel_addr), 64'(DEPTH));

    assign mem_we     = (grant != 2'b00) && sel_we && sel_legal;
    assign mem_addr   = sel_addr;
    assign mem_wdata  = sel_wdata;

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Illegal reads still respond, but with zero data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rvalid_q <= grant & {~req1_we, ~req0_we};
            err_q    <= grant & {2{~sel_legal}};
            if (grant[0] && !req0_we) begin
                rdata0_q <= sel_legal ? mem_rdata : '0;
            end
            if (grant[1] && !req1_we) begin
                rdata1_q <= sel_legal ? mem_rdata : '0;
            end
        end
    end

    assign req0_rvalid = rvalid_q[0];
    assign req1_rvalid = rvalid_q[1];
    assign req0_err    = err_q[0];
    assign req1_err    = err_q[1];
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked by a
// reference arbitration model, a reference memory image and a response scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int N         = 32;
    localparam int DEPTH     = 64;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        int          due;
        logic        is_read;
        logic        err;
        logic [31:0] data;
    } exp_t;

    // ---------------- clock / reset / pins ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_we, req0_lock, req0_rvalid, req0_err;
    logic         req1_valid, req1_ready, req1_we, req1_lock, req1_rvalid, req1_err;
    logic [N-1:0] req0_addr, req0_wdata, req0_rdata;
    logic [N-1:0] req1_addr, req1_wdata, req1_rdata;
    logic         mem_we;
    logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
    arb_state_t   dbg_state_o;

    always #5 clk = ~clk;

    dmem_arbiter #(.n(N), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state_o(dbg_state_o)
    );

    // Memory the arbiter drives: async read, write at the clock edge.
    logic [31:0] mem_arr [DEPTH];
    assign mem_rdata = mem_arr[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [DEPTH];
    int   m_owner = -1;   // port holding the lock, -1 when nobody does
    int   m_last  = 1;    // port that won most recently
    int   m_burst = 0;    // accepts so far in the current locked burst
    int   wait0 = 0, wait1 = 0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    req_t d0, d1;
    logic rst_drv;
    logic acc0, acc1;
    int   last_g;
    req_t q0[$], q1[$];
    int   gseq[$];
    int   exp_seq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic bit legal_ref(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < DEPTH);
    endfunction

    function automatic req_t idle_req();
        req_t r;
        r = '0;
        return r;
    endfunction

    function automatic req_t mk(input logic we, input logic lock, input logic [31:0] a,
                                input logic [31:0] wd);
        req_t r;
        r.valid = 1'b1; r.we = we; r.lock = lock; r.addr = a; r.wdata = wd;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   kind;
        r.valid = ($urandom_range(0, 9) < 7);
        r.we    = $urandom_range(0, 1) == 1;
        r.lock  = $urandom_range(0, 2) != 0;
        r.wdata = $urandom;
        kind    = $urandom_range(0, 9);
        if (kind < 7)       r.addr = 32'($urandom_range(0, DEPTH - 1) * 4);
        else if (kind == 7) r.addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        else if (kind == 8) r.addr = 32'($urandom_range(DEPTH, 2 * DEPTH - 1) * 4);
        else                r.addr = $urandom;
        return r;
    endfunction

    // ---------------- one clock cycle: drive, check, predict ----------------
    task automatic step();
        int   g;
        req_t r;
        exp_t e;
        bit   lk;
        @(posedge clk);
        cyc++;
        #1;
        rst_n      = rst_drv;
        req0_valid = d0.valid; req0_we = d0.we; req0_lock = d0.lock;
        req0_addr  = d0.addr;  req0_wdata = d0.wdata;
        req1_valid = d1.valid; req1_we = d1.we; req1_lock = d1.lock;
        req1_addr  = d1.addr;  req1_wdata = d1.wdata;
        #1;
        check("state", 32'(dbg_state_o),
              m_owner < 0 ? 32'(IDLE) : (m_owner == 0 ? 32'(OWN0) : 32'(OWN1)));

        if (!rst_drv)                 g = -1;
        else if (m_owner >= 0)        g = ((m_owner == 0) ? d0.valid : d1.valid) ? m_owner : -1;
        else if (d0.valid && d1.valid) g = 1 - m_last;
        else if (d0.valid)            g = 0;
        else if (d1.valid)            g = 1;
        else                          g = -1;

        check("ready0", 32'(req0_ready), 32'(g == 0));
        check("ready1", 32'(req1_ready), 32'(g == 1));
        r = (g == 1) ? d1 : d0;
        check("mem_we", 32'(mem_we), 32'(g >= 0 && r.we && legal_ref(r.addr)));
        check("mem_addr", mem_addr, (g >= 0) ? r.addr : 32'h0);
        check("mem_wdata", mem_wdata, (g >= 0) ? r.wdata : 32'h0);

        if (g >= 0) begin
            e.due     = cyc + 1;
            e.is_read = !r.we;
            e.err     = !legal_ref(r.addr);
            e.data    = (!r.we && legal_ref(r.addr)) ? ref_mem[r.addr / 4] : 32'h0;
            if (e.is_read || e.err) begin
                if (g == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
            end
            if (r.we && legal_ref(r.addr)) ref_mem[r.addr / 4] = r.wdata;
        end

        // Fairness: no request waits longer than MAX_BURST+1 cycles.
        if (g == 0) begin
            n_vec++;
            if (wait0 > MAX_BURST + 1) begin
                n_err++;
                $display("FAIL fair0: waited %0d cycles, limit %0d", wait0, MAX_BURST + 1);
            end
        end
        if (g == 1) begin
            n_vec++;
            if (wait1 > MAX_BURST + 1) begin
                n_err++;
                $display("FAIL fair1: waited %0d cycles, limit %0d", wait1, MAX_BURST + 1);
            end
        end
        if (!rst_drv) begin
            wait0 = 0; wait1 = 0;
        end else begin
            wait0 = (d0.valid && g != 0) ? wait0 + 1 : 0;
            wait1 = (d1.valid && g != 1) ? wait1 + 1 : 0;
        end

        if (!rst_drv) begin
            m_owner = -1; m_last = 1; m_burst = 0;
        end else if (m_owner >= 0) begin
            lk = (m_owner == 0) ? d0.lock : d1.lock;
            if (g >= 0 && lk && m_burst + 1 < MAX_BURST) begin
                m_burst++;
            end else begin
                m_last  = m_owner;
                m_owner = -1;
                m_burst = 0;
            end
        end else if (g >= 0) begin
            m_last = g;
            if (r.lock && MAX_BURST > 1) begin
                m_owner = g;
                m_burst = 1;
            end
        end
        acc0   = (g == 0);
        acc1   = (g == 1);
        last_g = g;
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon_port(input string nm, input bit hit, input exp_t e,
                            input logic rv, input logic [31:0] rd, input logic er);
        if (hit) begin
            check({nm, "_rvalid"}, 32'(rv), 32'(e.is_read));
            check({nm, "_err"}, 32'(er), 32'(e.err));
            if (e.is_read) check({nm, "_rdata"}, rd, e.data);
        end else begin
            check({nm, "_rvalid_idle"}, 32'(rv), 32'h0);
            check({nm, "_err_idle"}, 32'(er), 32'h0);
        end
    endtask

    initial begin
        exp_t e;
        bit   hit;
        forever begin
            @(negedge clk);
            hit = (exp_q0.size() > 0) && (exp_q0[0].due == cyc);
            e   = '0;
            if (hit) e = exp_q0.pop_front();
            mon_port("p0", hit, e, req0_rvalid, req0_rdata, req0_err);
            hit = (exp_q1.size() > 0) && (exp_q1[0].due == cyc);
            e   = '0;
            if (hit) e = exp_q1.pop_front();
            mon_port("p1", hit, e, req1_rvalid, req1_rdata, req1_err);
        end
    end

    // ---------------- directed-sequence driver ----------------
    task automatic run_queues(input int delay0, input int delay1, input int rst_at,
                              input int max_cycles);
        gseq.delete();
        for (int c = 0; c < max_cycles; c++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            d0 = idle_req();
            d1 = idle_req();
            if (c >= delay0 && q0.size() > 0) d0 = q0[0];
            if (c >= delay1 && q1.size() > 0) d1 = q1[0];
            rst_drv = (c != rst_at);
            step();
            gseq.push_back(last_g);
            if (acc0) void'(q0.pop_front());
            if (acc1) void'(q1.pop_front());
        end
        check("drain", 32'(q0.size() + q1.size()), 32'h0);
        q0.delete();
        q1.delete();
        d0 = idle_req();
        d1 = idle_req();
        rst_drv = 1'b1;
    endtask

    task automatic check_seq(input string nm);
        check({nm, "_len"}, 32'(gseq.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < gseq.size(); i++) begin
            check($sformatf("%s_g%0d", nm, i), gseq[i], exp_seq[i]);
        end
    endtask

    task automatic do_reset();
        d0 = idle_req();
        d1 = idle_req();
        rst_drv = 1'b0;
        step();
        step();
        rst_drv = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_lock = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_lock = 1'b0; req1_addr = '0; req1_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        acc0 = 1'b0; acc1 = 1'b0; last_g = -1;

        // Reset, then an idle cycle with everything quiet.
        do_reset();
        step();
        check("rdata0_rst", req0_rdata, 32'h0);
        check("rdata1_rst", req1_rdata, 32'h0);

        // Port 0 write then read back the same word.
        q0.push_back(mk(1'b1, 1'b0, 32'h10, 32'hDEADBEEF));
        q0.push_back(mk(1'b0, 1'b0, 32'h10, 32'h0));
        run_queues(0, 0, -1, 10);
        exp_seq = '{0, 0};
        check_seq("wr_rd");
        check("ref_word4", ref_mem[4], 32'hDEADBEEF);

        // Both ports reading every cycle, no lock: strict alternation from port 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 1'b0, 32'(i * 4), 32'h0));
            q1.push_back(mk(1'b0, 1'b0, 32'(i * 4 + 32), 32'h0));
        end
        run_queues(0, 0, -1, 20);
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
        check_seq("alt");

        // Port 1 locked burst of 6 reads against a continuously valid port 0.
        for (int i = 0; i < 6; i++) q1.push_back(mk(1'b0, 1'b1, 32'(i * 4 + 64), 32'h0));
        for (int i = 0; i < 2; i++) q0.push_back(mk(1'b0, 1'b0, 32'(i * 4 + 128), 32'h0));
        run_queues(1, 0, -1, 20);
        exp_seq = '{1, 1, 1, 1, 0, 1, 1, -1, 0};
        check_seq("burst");

        // Illegal accesses: misaligned read, out-of-range write.
        q0.push_back(mk(1'b0, 1'b0, 32'h102, 32'h0));
        q0.push_back(mk(1'b1, 1'b0, 32'h100, 32'h12345678));
        run_queues(0, 0, -1, 10);
        exp_seq = '{0, 0};
        check_seq("illegal");

        // Reset in the middle of a port-0 burst.
        for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, 1'b1, 32'(i * 4 + 8), 32'h0));
        for (int i = 0; i < 2; i++) q1.push_back(mk(1'b0, 1'b0, 32'(i * 4 + 200), 32'h0));
        run_queues(0, 3, 2, 20);
        exp_seq = '{0, 0, -1, 0, 0, -1, 1, 1};
        check_seq("rst_burst");

        // Random traffic with occasional resets; unaccepted requests are held.
        acc0 = 1'b0; acc1 = 1'b0;
        d0 = idle_req(); d1 = idle_req();
        for (int i = 0; i < 800; i++) begin
            rst_drv = ($urandom_range(0, 199) != 0);
            if (!(d0.valid && !acc0)) d0 = rand_req();
            if (!(d1.valid && !acc1)) d1 = rand_req();
            step();
        end

        d0 = idle_req(); d1 = idle_req(); rst_drv = 1'b1;
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        #1;
        check("pending_q", 32'(exp_q0.size() + exp_q1.size()), 32'h0);
        for (int i = 0; i < DEPTH; i++) check($sformatf("mem%0d", i), mem_arr[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
